// File: rtl/stopwatch_ctl_pkg.sv
// Shared encodings and widths for the stopwatch controller and its BCD counter.
package stopwatch_ctl_pkg;

    localparam int CNT_BIT_WIDTH      = 4;
    localparam int SW_STATE_BIT_WIDTH = 2;

    localparam logic [SW_STATE_BIT_WIDTH-1:0] SW_IDLE  = 2'd0;
    localparam logic [SW_STATE_BIT_WIDTH-1:0] SW_RUN   = 2'd1;
    localparam logic [SW_STATE_BIT_WIDTH-1:0] SW_PAUSE = 2'd2;
    localparam logic [SW_STATE_BIT_WIDTH-1:0] SW_LAP   = 2'd3;

    typedef logic [CNT_BIT_WIDTH-1:0]      bcd_t;
    typedef logic [SW_STATE_BIT_WIDTH-1:0] sw_state_t;

    function automatic logic is_counting(input sw_state_t st);
        return (st == SW_RUN) || (st == SW_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctl_bcd2_cnt.sv
// Two-digit BCD counter with programmable terminal digits; wraps to 00 after the terminal count.
module stopwatch_ctl_bcd2_cnt
    import stopwatch_ctl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  bcd_t max_tens,
    input  bcd_t max_ones,
    output bcd_t ones,
    output bcd_t tens,
    output bcd_t ones_nxt,
    output bcd_t tens_nxt,
    output logic at_max
);

    bcd_t ones_q, ones_d;
    bcd_t tens_q, tens_d;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (clr) begin
            ones_d = '0;
            tens_d = '0;
        end else if (en) begin
            // Compare with >= so a corrupted digit still falls back into range.
            if (ones_q >= max_ones) begin
                ones_d = '0;
                tens_d = (tens_q >= max_tens) ? '0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones     = ones_q;
    assign tens     = tens_q;
    assign ones_nxt = ones_d;
    assign tens_nxt = tens_d;
    assign at_max   = (ones_q == max_ones) && (tens_q == max_tens);

endmodule

// File: rtl/stopwatch_ctl.sv
// Start/stop/lap/reset sequencer: owns the FSM, lap snapshot, sticky overflow and display registers.
module stopwatch_ctl
    import stopwatch_ctl_pkg::*;
#(
    parameter int MAX_TENS = 9,
    parameter int MAX_ONES = 9,
    parameter bit WRAP_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic [3:0] disp0,
    output logic [3:0] disp1,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam bcd_t MAX_T = bcd_t'(MAX_TENS);
    localparam bcd_t MAX_O = bcd_t'(MAX_ONES);

    sw_state_t state_q, state_d;
    bcd_t      lap_ones_q, lap_ones_d;
    bcd_t      lap_tens_q, lap_tens_d;
    logic      ovf_q, ovf_d;
    bcd_t      disp0_q, disp1_q;
    logic      running_q, lap_active_q;

    logic cnt_tick, cnt_en, cnt_clr, at_max, terminal;
    bcd_t ones, tens, ones_nxt, tens_nxt;

    // Qualified on the pre-transition state so IDLE->RUN ignores a coincident tick.
    assign cnt_tick = tick && is_counting(state_q);
    assign terminal = cnt_tick && at_max;
    assign cnt_en   = cnt_tick && !(at_max && !WRAP_EN);

    stopwatch_ctl_bcd2_cnt u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .max_tens (MAX_T),
        .max_ones (MAX_O),
        .ones     (ones),
        .tens     (tens),
        .ones_nxt (ones_nxt),
        .tens_nxt (tens_nxt),
        .at_max   (at_max)
    );

    always_comb begin
        state_d    = state_q;
        lap_ones_d = lap_ones_q;
        lap_tens_d = lap_tens_q;
        ovf_d      = ovf_q;
        cnt_clr    = 1'b0;
        unique case (state_q)
            SW_IDLE: if (btn_ss) state_d = SW_RUN;
            SW_RUN: begin
                if (btn_ss) begin
                    state_d = SW_PAUSE;
                end else if (btn_lr) begin
                    state_d    = SW_LAP;
                    lap_ones_d = ones;
                    lap_tens_d = tens;
                end
            end
            SW_LAP: begin
                if (btn_ss)      state_d = SW_PAUSE;
                else if (btn_lr) state_d = SW_RUN;
            end
            default: begin
                if (btn_ss) begin
                    state_d = SW_RUN;
                end else if (btn_lr) begin
                    state_d = SW_IDLE;
                    cnt_clr = 1'b1;
                    ovf_d   = 1'b0;
                end
            end
        endcase
        // Terminal count overrides any button-driven transition when saturating.
        if (terminal) begin
            ovf_d = 1'b1;
            if (!WRAP_EN) state_d = SW_PAUSE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SW_IDLE;
            lap_ones_q   <= '0;
            lap_tens_q   <= '0;
            ovf_q        <= 1'b0;
            disp0_q      <= '0;
            disp1_q      <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lap_ones_q   <= lap_ones_d;
            lap_tens_q   <= lap_tens_d;
            ovf_q        <= ovf_d;
            disp0_q      <= (state_d == SW_LAP) ? lap_ones_d : ones_nxt;
            disp1_q      <= (state_d == SW_LAP) ? lap_tens_d : tens_nxt;
            running_q    <= is_counting(state_d);
            lap_active_q <= (state_d == SW_LAP);
        end
    end

    assign disp0      = disp0_q;
    assign disp1      = disp1_q;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctl.sv
// Directed bench for two stopwatch_ctl builds (wrapping 99 and saturating 59) with a decimal reference model.
module tb_stopwatch_ctl;

    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_LAP   = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [10:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n_v  [2];
    logic       tick_v   [2];
    logic       ss_v     [2];
    logic       lr_v     [2];
    logic [3:0] d0_v     [2];
    logic [3:0] d1_v     [2];
    logic       run_v    [2];
    logic       lapa_v   [2];
    logic       ovf_v    [2];

    int  m_st [2];
    int  m_cnt[2];
    int  m_lap[2];
    bit  m_ovf[2];
    int  lim  [2] = '{99, 59};
    bit  wrap [2] = '{1'b1, 1'b0};

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    stopwatch_ctl #(.MAX_TENS(9), .MAX_ONES(9), .WRAP_EN(1'b1)) dut_wrap (
        .clk(clk), .rst_n(rst_n_v[0]), .tick(tick_v[0]), .btn_ss(ss_v[0]), .btn_lr(lr_v[0]),
        .disp0(d0_v[0]), .disp1(d1_v[0]), .running(run_v[0]), .lap_active(lapa_v[0]),
        .overflow(ovf_v[0])
    );

    stopwatch_ctl #(.MAX_TENS(5), .MAX_ONES(9), .WRAP_EN(1'b0)) dut_sat (
        .clk(clk), .rst_n(rst_n_v[1]), .tick(tick_v[1]), .btn_ss(ss_v[1]), .btn_lr(lr_v[1]),
        .disp0(d0_v[1]), .disp1(d1_v[1]), .running(run_v[1]), .lap_active(lapa_v[1]),
        .overflow(ovf_v[1])
    );

    function automatic logic [10:0] obs(input int sel);
        return {d1_v[sel], d0_v[sel], run_v[sel], lapa_v[sel], ovf_v[sel]};
    endfunction

    function automatic logic [10:0] pk(input int t, input int o, input bit r, input bit l, input bit v);
        return {4'(t), 4'(o), r, l, v};
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            rst_n_v[i] = 1'b1;
            tick_v[i]  = 1'b0;
            ss_v[i]    = 1'b0;
            lr_v[i]    = 1'b0;
        end
    endtask

    // One clock of stimulus on one DUT; the model predicts, the scoreboard checks after the edge.
    task automatic step(input int sel, input bit ss, input bit lr, input bit tk, input bit rn,
                        input string tag);
        int   ns;
        int   dv;
        bit   en;
        exp_t e;
        exp_t got;
        if (!rn) begin
            m_st[sel] = ST_IDLE; m_cnt[sel] = 0; m_lap[sel] = 0; m_ovf[sel] = 1'b0;
        end else begin
            en = tk && (m_st[sel] == ST_RUN || m_st[sel] == ST_LAP);
            ns = m_st[sel];
            case (m_st[sel])
                ST_IDLE: if (ss) ns = ST_RUN;
                ST_RUN: begin
                    if (ss) ns = ST_PAUSE;
                    else if (lr) begin ns = ST_LAP; m_lap[sel] = m_cnt[sel]; end
                end
                ST_LAP: begin
                    if (ss) ns = ST_PAUSE;
                    else if (lr) ns = ST_RUN;
                end
                default: begin
                    if (ss) ns = ST_RUN;
                    else if (lr) begin ns = ST_IDLE; m_cnt[sel] = 0; m_ovf[sel] = 1'b0; end
                end
            endcase
            if (en) begin
                if (m_cnt[sel] == lim[sel]) begin
                    m_ovf[sel] = 1'b1;
                    if (wrap[sel]) m_cnt[sel] = 0;
                    else ns = ST_PAUSE;
                end else begin
                    m_cnt[sel] = m_cnt[sel] + 1;
                end
            end
            m_st[sel] = ns;
        end
        dv    = (m_st[sel] == ST_LAP) ? m_lap[sel] : m_cnt[sel];
        e.tag = tag;
        e.sel = sel;
        e.v   = pk(dv / 10, dv % 10, m_st[sel] == ST_RUN || m_st[sel] == ST_LAP,
                   m_st[sel] == ST_LAP, m_ovf[sel]);
        sb.push_back(e);

        rst_n_v[sel] = rn;
        ss_v[sel]    = ss;
        lr_v[sel]    = lr;
        tick_v[sel]  = tk;
        @(posedge clk);
        #1;
        idle_inputs();

        got = sb.pop_front();
        n_assert++;
        assert (obs(got.sel) === got.v) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", got.tag, got.sel, obs(got.sel), got.v);
        end
    endtask

    task automatic ticks(input int sel, input int n, input string tag);
        for (int i = 0; i < n; i++) step(sel, 1'b0, 1'b0, 1'b1, 1'b1, tag);
    endtask

    // Fixed expectations taken directly from the intended behaviour, independent of the model.
    task automatic chk(input int sel, input string tag, input logic [10:0] v);
        n_assert++;
        assert (obs(sel) === v) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, sel, obs(sel), v);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n_v[0] = 1'b0;
        rst_n_v[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = ST_IDLE; m_cnt[i] = 0; m_lap[i] = 0; m_ovf[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();

        // Wrapping build, terminal 99
        step(0, 0, 0, 0, 0, "reset_a");
        chk(0, "reset_a_const", pk(0, 0, 0, 0, 0));
        step(0, 0, 1, 0, 1, "idle_lr_ignored");
        step(0, 1, 0, 1, 1, "idle_to_run_tick");
        chk(0, "idle_to_run_no_inc", pk(0, 0, 1, 0, 0));
        ticks(0, 12, "count_to_12");
        chk(0, "run_12", pk(1, 2, 1, 0, 0));
        step(0, 1, 0, 0, 1, "run_to_pause");
        ticks(0, 3, "pause_ticks");
        chk(0, "pause_holds_12", pk(1, 2, 0, 0, 0));
        step(0, 1, 0, 0, 1, "pause_to_run");
        step(0, 1, 0, 1, 1, "run_to_pause_tick");
        chk(0, "stop_tick_increments", pk(1, 3, 0, 0, 0));
        step(0, 0, 1, 0, 1, "pause_to_idle");
        chk(0, "idle_cleared", pk(0, 0, 0, 0, 0));
        step(0, 1, 0, 0, 1, "start_again");
        ticks(0, 7, "count_to_07");
        step(0, 0, 1, 0, 1, "lap_at_07");
        chk(0, "lap_shows_07", pk(0, 7, 1, 1, 0));
        ticks(0, 5, "lap_ticks");
        chk(0, "lap_frozen_07", pk(0, 7, 1, 1, 0));
        step(0, 0, 1, 0, 1, "lap_release");
        chk(0, "release_shows_12", pk(1, 2, 1, 0, 0));
        ticks(0, 22, "count_to_34");
        chk(0, "run_34", pk(3, 4, 1, 0, 0));
        step(0, 0, 1, 1, 1, "lap_with_tick");
        chk(0, "lap_pre_increment", pk(3, 4, 1, 1, 0));
        step(0, 1, 0, 0, 1, "lap_to_pause");
        chk(0, "pause_live_35", pk(3, 5, 0, 0, 0));
        step(0, 1, 1, 0, 1, "ss_wins_over_lr");
        chk(0, "ss_wins_no_clear", pk(3, 5, 1, 0, 0));
        ticks(0, 64, "count_to_99");
        chk(0, "run_99", pk(9, 9, 1, 0, 0));
        step(0, 0, 0, 1, 1, "wrap_tick");
        chk(0, "wrap_to_00", pk(0, 0, 1, 0, 1));
        step(0, 0, 0, 1, 1, "after_wrap");
        step(0, 1, 0, 0, 1, "wrap_pause");
        step(0, 0, 1, 0, 1, "wrap_clear");
        chk(0, "overflow_cleared", pk(0, 0, 0, 0, 0));
        step(0, 1, 0, 0, 1, "run_for_lap_reset");
        ticks(0, 3, "pre_lap_reset");
        step(0, 0, 1, 1, 1, "lap_for_reset");
        step(0, 1, 1, 1, 0, "reset_mid_lap");
        chk(0, "reset_mid_lap_zero", pk(0, 0, 0, 0, 0));

        // Saturating build, terminal 59
        step(1, 0, 0, 0, 0, "reset_b");
        step(1, 1, 0, 0, 1, "b_start");
        ticks(1, 59, "b_count_to_59");
        chk(1, "b_run_59", pk(5, 9, 1, 0, 0));
        step(1, 0, 1, 0, 1, "b_lap_59");
        step(1, 0, 0, 1, 1, "b_sat_in_lap");
        chk(1, "b_sat_forces_pause", pk(5, 9, 0, 0, 1));
        step(1, 1, 0, 0, 1, "b_resume");
        step(1, 0, 1, 0, 1, "b_lap_again");
        step(1, 0, 1, 1, 1, "b_sat_overrides_lr");
        chk(1, "b_lr_overridden", pk(5, 9, 0, 0, 1));
        step(1, 0, 0, 1, 1, "b_pause_tick");
        step(1, 1, 0, 0, 1, "b_resume2");
        step(1, 0, 0, 1, 1, "b_sat_in_run");
        step(1, 0, 1, 0, 1, "b_clear");
        chk(1, "b_cleared", pk(0, 0, 0, 0, 0));
        step(1, 1, 0, 0, 1, "b_start2");
        ticks(1, 5, "b_count_5");
        step(1, 1, 0, 1, 0, "b_reset_mid_run");
        chk(1, "b_reset_zero", pk(0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
